// File: rtl/cpu_seq.sv
// Command sequencer for a small CPU core: a DEPTH-entry command FIFO feeds a
// four-state issue FSM, and ALU results are returned through a valid/ready register.
module cpu_seq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_sel,
  input  logic [3:0] cmd_op,
  input  logic       cmd_cin,
  input  logic [7:0] cmd_data,
  output logic       cpu_ce,
  output logic       cpu_load,
  output logic [6:0] cpu_opcode,
  output logic       cpu_cin,
  output logic [7:0] cpu_data_in,
  input  logic [7:0] cpu_data_out,
  input  logic       cpu_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_cout,
  output logic       busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       load;
    logic [2:0] sel;
    logic [3:0] op;
    logic       cin;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e          state_q, state_d;
  cmd_t            mem_q [DEPTH];
  cmd_t            iss_q;
  cmd_t            head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            res_valid_q, res_cout_q;
  logic [7:0]      res_data_q;
  logic            push, pop, slot_free;

  assign cmd_ready = (count_q != CntW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  // The result slot counts as free when it is being consumed on this same edge, so
  // back-to-back operations sustain one issue every four cycles.
  assign slot_free = !res_valid_q || res_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0) && (head.load || slot_free);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pop) state_d = StIssue;
      StIssue:   state_d = iss_q.load ? StIdle : StWait;
      StWait:    state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      iss_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {cmd_load, cmd_sel, cmd_op, cmd_cin, cmd_data};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        iss_q    <= head;
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
    end else if (state_q == StCapture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= cpu_data_out;
      res_cout_q  <= cpu_cout;
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Issue-register fields stay on the CPU bus between issues; only ce/load pulse.
  assign cpu_ce      = (state_q == StIssue);
  assign cpu_load    = cpu_ce && iss_q.load;
  assign cpu_opcode  = {iss_q.sel, iss_q.op};
  assign cpu_cin     = iss_q.cin;
  assign cpu_data_in = iss_q.data;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;
  assign busy      = (state_q != StIdle) || (count_q != '0);

endmodule
